// File: rtl/sum_checker.sv
// sum_checker: compares an adder's output against golden vectors, sample by
// sample, and reports how many samples were seen, how many mismatched, and
// the address of the first mismatch in the run.
//
// Two-stage pipeline: stage 1 registers the incoming sample, stage 2 compares
// the registered copies and updates the error bookkeeping. A mismatch
// therefore lands in err_count two cycles after its valid_in cycle. The
// two-cycle DRAIN state lets the last accepted sample reach stage 2 before
// done is raised.
module sum_checker #(
    parameter  int RADIX      = 8,
    parameter  int DIGITS     = 11,
    parameter  int ADDR_WIDTH = 11,
    localparam int DW         = $clog2(RADIX) + 1,
    localparam int BITS_OUT   = DW * (DIGITS + 1),
    localparam int CW         = ADDR_WIDTH + 1
) (
    input  logic                  pll_clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  clear,
    input  logic [CW-1:0]         num_tests,
    input  logic                  valid_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [BITS_OUT-1:0]   sum_in,
    input  logic [BITS_OUT-1:0]   expected_in,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         sample_count,
    output logic [CW-1:0]         err_count,
    output logic                  first_err_valid,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    // Largest run the result RAM can address: 2^ADDR_WIDTH samples.
    localparam logic [CW-1:0] MAX_TESTS = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_reg;
    logic                  drain_reg;
    logic [CW-1:0]         num_reg;
    logic [CW-1:0]         sample_count_reg;
    logic [CW-1:0]         err_count_reg;
    logic                  first_err_valid_reg;
    logic [ADDR_WIDTH-1:0] first_err_addr_reg;

    logic                  s1_valid_reg;
    logic [ADDR_WIDTH-1:0] s1_addr_reg;
    logic [BITS_OUT-1:0]   s1_sum_reg;
    logic [BITS_OUT-1:0]   s1_exp_reg;

    logic [CW-1:0]         num_clamped;
    logic                  accept;
    logic                  s1_mismatch;

    assign num_clamped = (num_tests > MAX_TESTS) ? MAX_TESTS : num_tests;
    // A clear in the same cycle as valid_in discards that sample too.
    assign accept      = (state_reg == S_RUN) && valid_in && !clear;
    assign s1_mismatch = s1_valid_reg && (s1_sum_reg != s1_exp_reg);

    // Stage-1 data capture; only the valid bit needs a reset, the payload is
    // ignored whenever it is not qualified.
    always_ff @(posedge pll_clock) begin
        if (accept) begin
            s1_addr_reg <= addr_in;
            s1_sum_reg  <= sum_in;
            s1_exp_reg  <= expected_in;
        end
    end

    // Control FSM, counters, stage-2 error bookkeeping and stage-1 valid bit.
    always_ff @(posedge pll_clock or negedge resetn) begin
        if (!resetn) begin
            state_reg           <= S_IDLE;
            drain_reg           <= 1'b0;
            num_reg             <= '0;
            sample_count_reg    <= '0;
            err_count_reg       <= '0;
            first_err_valid_reg <= 1'b0;
            first_err_addr_reg  <= '0;
            s1_valid_reg        <= 1'b0;
        end else if (clear) begin
            state_reg           <= S_IDLE;
            drain_reg           <= 1'b0;
            sample_count_reg    <= '0;
            err_count_reg       <= '0;
            first_err_valid_reg <= 1'b0;
            first_err_addr_reg  <= '0;
            s1_valid_reg        <= 1'b0;
        end else begin
            s1_valid_reg <= accept;

            if (s1_mismatch) begin
                err_count_reg <= err_count_reg + CW'(1);
                if (!first_err_valid_reg) begin
                    first_err_valid_reg <= 1'b1;
                    first_err_addr_reg  <= s1_addr_reg;
                end
            end

            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        num_reg             <= num_clamped;
                        sample_count_reg    <= '0;
                        err_count_reg       <= '0;
                        first_err_valid_reg <= 1'b0;
                        first_err_addr_reg  <= '0;
                        drain_reg           <= 1'b0;
                        state_reg           <= (num_clamped == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        sample_count_reg <= sample_count_reg + CW'(1);
                        if (sample_count_reg + CW'(1) == num_reg) begin
                            state_reg <= S_DRAIN;
                            drain_reg <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_reg) begin
                        state_reg <= S_DONE;
                    end
                    drain_reg <= 1'b1;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy            = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign done            = (state_reg == S_DONE);
    assign sample_count    = sample_count_reg;
    assign err_count       = err_count_reg;
    assign first_err_valid = first_err_valid_reg;
    assign first_err_addr  = first_err_addr_reg;

endmodule

// File: tb/tb_sum_checker.sv
// Directed testbench for sum_checker: a linear sequence of hand-computed
// steps covering reset, matching and mismatching runs, an empty run, the
// num_tests clamp, clear-versus-start priority and reset during DRAIN.
module tb_sum_checker;

    localparam int RADIX = 8;
    localparam int DIGITS = 11;
    localparam int AW = 11;
    localparam int DW = $clog2(RADIX) + 1;
    localparam int BO = DW * (DIGITS + 1);
    localparam int CW = AW + 1;

    logic          pll_clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [CW-1:0] num_tests = '0;
    logic          valid_in = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [BO-1:0] sum_in = '0;
    logic [BO-1:0] expected_in = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] sample_count;
    logic [CW-1:0] err_count;
    logic          first_err_valid;
    logic [AW-1:0] first_err_addr;

    int compared = 0;
    int mismatched = 0;

    sum_checker #(.RADIX(RADIX), .DIGITS(DIGITS), .ADDR_WIDTH(AW)) dut (
        .pll_clock      (pll_clock),
        .resetn         (resetn),
        .start          (start),
        .clear          (clear),
        .num_tests      (num_tests),
        .valid_in       (valid_in),
        .addr_in        (addr_in),
        .sum_in         (sum_in),
        .expected_in    (expected_in),
        .busy           (busy),
        .done           (done),
        .sample_count   (sample_count),
        .err_count      (err_count),
        .first_err_valid(first_err_valid),
        .first_err_addr (first_err_addr)
    );

    always #5 pll_clock = ~pll_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed and inputs changed 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge pll_clock);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [BO-1:0] s, input logic [BO-1:0] e);
        valid_in    = 1'b1;
        addr_in     = a;
        sum_in      = s;
        expected_in = e;
    endtask

    logic [BO-1:0] base;

    initial begin
        base = 48'hA5C3_1234_9F0E;

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sample", 32'(sample_count), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_fev", 32'(first_err_valid), 0);
        check("rst_fea", 32'(first_err_addr), 0);
        resetn = 1'b1;
        tick();

        // Four matching samples
        num_tests = 12'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy_run", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            drive(AW'(i), base ^ BO'(i), base ^ BO'(i));
            tick();
        end
        valid_in = 1'b0;
        check("t1_sample", 32'(sample_count), 4);
        check("t1_busy_drain", 32'(busy), 1);
        check("t1_done_c1", 32'(done), 0);
        tick();
        check("t1_done_c2", 32'(done), 0);
        tick();
        check("t1_done_c3", 32'(done), 1);
        check("t1_busy_done", 32'(busy), 0);
        check("t1_err", 32'(err_count), 0);
        check("t1_fev", 32'(first_err_valid), 0);

        // valid_in in DONE is ignored
        drive(AW'(1), base, ~base);
        tick();
        tick();
        valid_in = 1'b0;
        tick();
        check("t1_ign_sample", 32'(sample_count), 4);
        check("t1_ign_err", 32'(err_count), 0);

        // Mismatches at addr 5 and 9, match at 7; start from DONE
        num_tests = 12'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_start_sample", 32'(sample_count), 0);
        drive(AW'(5), base, base ^ (BO'(1) << (BO - 1)));
        tick();
        check("t2_a_sample", 32'(sample_count), 1);
        check("t2_a_err", 32'(err_count), 0);
        drive(AW'(7), base ^ 48'h77, base ^ 48'h77);
        tick();
        check("t2_b_err", 32'(err_count), 1);
        check("t2_b_fev", 32'(first_err_valid), 1);
        check("t2_b_fea", 32'(first_err_addr), 5);
        drive(AW'(9), base, base ^ 48'h1);
        tick();
        valid_in = 1'b0;
        check("t2_c_sample", 32'(sample_count), 3);
        check("t2_c_err", 32'(err_count), 1);
        tick();
        check("t2_d_err", 32'(err_count), 2);
        check("t2_d_fea", 32'(first_err_addr), 5);
        check("t2_d_done", 32'(done), 0);
        tick();
        check("t2_e_done", 32'(done), 1);

        // Clear, then empty run
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t3_clr_done", 32'(done), 0);
        check("t3_clr_err", 32'(err_count), 0);
        check("t3_clr_fev", 32'(first_err_valid), 0);
        num_tests = 12'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_done", 32'(done), 1);
        check("t3_busy", 32'(busy), 0);
        check("t3_sample", 32'(sample_count), 0);

        // start ignored in RUN; clear+start mid-run
        num_tests = 12'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        drive(AW'(3), base, base ^ 48'h100);
        tick();
        drive(AW'(4), base, base);
        tick();
        valid_in = 1'b0;
        num_tests = 12'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_run_busy", 32'(busy), 1);
        check("t4_run_sample", 32'(sample_count), 2);
        check("t4_run_err", 32'(err_count), 1);
        check("t4_run_fea", 32'(first_err_addr), 3);
        drive(AW'(6), base, ~base);
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        valid_in = 1'b0;
        check("t4_clr_busy", 32'(busy), 0);
        check("t4_clr_sample", 32'(sample_count), 0);
        check("t4_clr_fea", 32'(first_err_addr), 0);
        tick();
        tick();
        check("t4_idle_busy", 32'(busy), 0);
        check("t4_idle_done", 32'(done), 0);
        check("t4_idle_err", 32'(err_count), 0);

        // Clamp 4095 -> 2048
        num_tests = 12'd4095;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2047; i++) begin
            if (i == 100) drive(AW'(i), base, base ^ 48'h8000);
            else          drive(AW'(i), base ^ BO'(i), base ^ BO'(i));
            tick();
        end
        check("t5_sample_2047", 32'(sample_count), 2047);
        check("t5_err", 32'(err_count), 1);
        check("t5_fea", 32'(first_err_addr), 100);
        drive(AW'(2047), base, base);
        tick();
        check("t5_sample_2048", 32'(sample_count), 2048);
        tick();
        tick();
        valid_in = 1'b0;
        check("t5_sample_hold", 32'(sample_count), 2048);
        check("t5_done", 32'(done), 1);

        // Reset during DRAIN discards pipelined mismatch
        num_tests = 12'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) drive(AW'(2), base, base ^ 48'h40);
            else        drive(AW'(i), base, base);
            tick();
        end
        valid_in = 1'b0;
        check("t6_drain_busy", 32'(busy), 1);
        resetn = 1'b0;
        #1;
        check("t6_async_busy", 32'(busy), 0);
        check("t6_async_sample", 32'(sample_count), 0);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        check("t6_err", 32'(err_count), 0);
        check("t6_fev", 32'(first_err_valid), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_done", 32'(done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
